// File: rtl/complete_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// complete_arbiter_pkg
// Shared types and widths for the completion broadcast path.
//   XLEN       : data width of result / rs2_value
//   NUM_FU     : default number of functional units requesting completion
//   ROB_IDX_W  : width of a ROB index
//   TAG_W      : width of a physical register tag
//   complete_packet_t : one completion (rob_idx, tag, result, rs2_value,
//                       take_branch)
//   ic_rob_packet_t   : the ROB-facing view of a completion, built from a
//                       complete_packet_t by to_ic_rob()
// -----------------------------------------------------------------------------
`ifndef ROB_SZ
`define ROB_SZ 32
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif
`ifndef NUM_FU
`define NUM_FU 4
`endif

package complete_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_FU    = `NUM_FU;
  localparam int ROB_IDX_W = $clog2(`ROB_SZ);
  localparam int TAG_W     = $clog2(`PHYS_REG_SZ);

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [TAG_W-1:0]     tag;
    logic [XLEN-1:0]      result;
    logic [XLEN-1:0]      rs2_value;
    logic                 take_branch;
  } complete_packet_t;

  typedef struct packed {
    logic                 complete_en;
    logic [ROB_IDX_W-1:0] complete_idx;
    logic [XLEN-1:0]      result;
    logic [XLEN-1:0]      rs2_value;
    logic                 take_branch;
  } ic_rob_packet_t;

  function automatic ic_rob_packet_t to_ic_rob(input logic valid,
                                               input complete_packet_t pkt);
    ic_rob_packet_t p;
    p.complete_en  = valid;
    p.complete_idx = pkt.rob_idx;
    p.result       = pkt.result;
    p.rs2_value    = pkt.rs2_value;
    p.take_branch  = pkt.take_branch;
    return p;
  endfunction

endpackage

// File: rtl/complete_arbiter_if.sv
// -----------------------------------------------------------------------------
// complete_arbiter_if
// Request side and broadcast side of the completion arbiter.
//   req_*  : per-FU completion requests, requester i in slice [i*W +: W]
//   req_ready : per-FU grant back to the functional units
//   out_stall : downstream back-pressure
//   out_*  : registered completion broadcast (out_valid is complete_en)
// modport master : the environment (FUs + ROB/RS consumer)
// modport slave  : the arbiter
// -----------------------------------------------------------------------------
interface complete_arbiter_if
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_FU
) ();

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ*TAG_W-1:0]     req_tag;
  logic [NUM_REQ*XLEN-1:0]      req_result;
  logic [NUM_REQ*XLEN-1:0]      req_rs2_value;
  logic [NUM_REQ-1:0]           req_take_branch;
  logic                         out_stall;
  logic                         out_valid;
  logic [ROB_IDX_W-1:0]         out_rob_idx;
  logic [TAG_W-1:0]             out_tag;
  logic [XLEN-1:0]              out_result;
  logic [XLEN-1:0]              out_rs2_value;
  logic                         out_take_branch;
  logic [SRC_W-1:0]             out_src;

  modport master (
    output req_valid, req_rob_idx, req_tag, req_result, req_rs2_value,
           req_take_branch, out_stall,
    input  req_ready, out_valid, out_rob_idx, out_tag, out_result,
           out_rs2_value, out_take_branch, out_src
  );

  modport slave (
    input  req_valid, req_rob_idx, req_tag, req_result, req_rs2_value,
           req_take_branch, out_stall,
    output req_ready, out_valid, out_rob_idx, out_tag, out_result,
           out_rs2_value, out_take_branch, out_src
  );

endinterface

// File: rtl/complete_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The request vector is rotated so that
// position ptr becomes bit 0, the lowest set bit is found, and the index is
// rotated back.
//   req       : request vector
//   ptr       : highest-priority position this cycle
//   en        : when low, no grant is produced
//   grant     : one-hot grant (all zero when none)
//   grant_idx : binary index of the granted requester
//   any_grant : a grant was produced
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_grant
);

  localparam logic [W:0] N_W = (W+1)'(N);

  logic [N-1:0] rot;
  logic [W-1:0] enc;
  logic         found;
  logic [W:0]   sum;

  // Rotate right by ptr: bits below ptr wrap to the top.
  assign rot = (req >> ptr) | (req << (N - int'(ptr)));

  // NOTE: every variable driven here gets a value before any condition so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    enc   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc   = W'(i);
        found = 1'b1;
      end
    end
  end

  // Unrotate: (enc + ptr) mod N, with both operands already below N.
  assign sum       = {1'b0, enc} + {1'b0, ptr};
  assign grant_idx = (sum >= N_W) ? W'(sum - N_W) : W'(sum);
  assign any_grant = en && found;
  assign grant     = any_grant ? (N'(1) << grant_idx) : '0;

endmodule

// File: rtl/complete_arbiter.sv
// -----------------------------------------------------------------------------
// complete_arbiter
// Picks one functional-unit completion per cycle (round robin) and registers it
// onto the single completion broadcast seen by the ROB and tag wakeup.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   flush : synchronous squash; drops the registered completion, blocks grants
//   bus   : complete_arbiter_if.slave (requests in, broadcast out)
// The output stage accepts a new completion whenever it is empty or being
// consumed this cycle (can_load), so back-to-back completions flow at one per
// cycle; out_stall reaches req_ready only through can_load.
// -----------------------------------------------------------------------------
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_FU
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  complete_arbiter_if.slave bus
);

  localparam int               SRC_W = $clog2(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST  = SRC_W'(NUM_REQ - 1);

  logic               can_load;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               any_grant;
  complete_packet_t   sel_pkt;

  logic               out_valid_q, out_valid_d;
  complete_packet_t   out_pkt_q,   out_pkt_d;
  logic [SRC_W-1:0]   out_src_q,   out_src_d;
  logic [SRC_W-1:0]   ptr_q,       ptr_d;

  assign can_load = !out_valid_q || !bus.out_stall;
  // Flush and reset both block the transfer, so no FU hands off a completion
  // that would be dropped.
  assign arb_en   = can_load && !flush && !reset;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign bus.req_ready = grant;

  always_comb begin
    sel_pkt.rob_idx     = bus.req_rob_idx[grant_idx*ROB_IDX_W +: ROB_IDX_W];
    sel_pkt.tag         = bus.req_tag[grant_idx*TAG_W +: TAG_W];
    sel_pkt.result      = bus.req_result[grant_idx*XLEN +: XLEN];
    sel_pkt.rs2_value   = bus.req_rs2_value[grant_idx*XLEN +: XLEN];
    sel_pkt.take_branch = bus.req_take_branch[grant_idx];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pkt_d   = out_pkt_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (can_load) begin
      // With no grant the slot empties; data fields keep their stale values.
      out_valid_d = any_grant;
      if (any_grant) begin
        out_pkt_d = sel_pkt;
        out_src_d = grant_idx;
        ptr_d     = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the data fields are reset along with out_valid so the broadcast
      // bus reads as all-zero out of reset rather than X.
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_rob_idx     = out_pkt_q.rob_idx;
  assign bus.out_tag         = out_pkt_q.tag;
  assign bus.out_result      = out_pkt_q.result;
  assign bus.out_rs2_value   = out_pkt_q.rs2_value;
  assign bus.out_take_branch = out_pkt_q.take_branch;
  assign bus.out_src         = out_src_q;

endmodule

// File: tb/tb_complete_arbiter.sv
// -----------------------------------------------------------------------------
// tb_complete_arbiter
// Directed bench for complete_arbiter with four requesters. Inputs change on
// the falling edge; req_ready is sampled 1 ns after that, registered outputs
// on the following falling edge.
// -----------------------------------------------------------------------------
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int SRC_W = 2;
  localparam int OUT_W = 1 + SRC_W + ROB_IDX_W + TAG_W + 2*XLEN + 1;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ROB_IDX_W-1:0] rob_tab [N];
  logic [TAG_W-1:0]     tag_tab [N];
  logic [XLEN-1:0]      res_tab [N];
  logic [XLEN-1:0]      rs2_tab [N];
  logic                 br_tab  [N];

  complete_arbiter_if #(.NUM_REQ(N)) bus ();

  complete_arbiter #(.NUM_REQ(N)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Expected broadcast for a completion from requester src.
  function automatic logic [OUT_W-1:0] exp_out(input int src);
    return {1'b1, SRC_W'(src), rob_tab[src], tag_tab[src], res_tab[src],
            rs2_tab[src], br_tab[src]};
  endfunction

  function automatic logic [OUT_W-1:0] act_out();
    return {bus.out_valid, bus.out_src, bus.out_rob_idx, bus.out_tag,
            bus.out_result, bus.out_rs2_value, bus.out_take_branch};
  endfunction

  task automatic load_tables();
    for (int i = 0; i < N; i++) begin
      rob_tab[i] = ROB_IDX_W'(i*7 + 3);
      tag_tab[i] = TAG_W'(40 + i);
      res_tab[i] = XLEN'(32'hA5A5_0000 + i);
      rs2_tab[i] = XLEN'(32'h5A5A_0000 + i*16);
      br_tab[i]  = (i % 2) == 1;
      bus.req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W] = rob_tab[i];
      bus.req_tag[i*TAG_W +: TAG_W]             = tag_tab[i];
      bus.req_result[i*XLEN +: XLEN]            = res_tab[i];
      bus.req_rs2_value[i*XLEN +: XLEN]         = rs2_tab[i];
      bus.req_take_branch[i]                    = br_tab[i];
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    flush         = 1'b0;
    bus.out_stall = 1'b0;
    bus.req_valid = 4'b1111;
    repeat (2) @(negedge clock);
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
    end
    n_checks++;
    if (act_out() !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got %h expected 0", act_out());
    end
    bus.req_valid = 4'b0000;
    reset         = 1'b0;
  endtask

  // ptr = 0 on entry; all four held valid for 8 cycles.
  task automatic test_round_robin();
    logic [N-1:0] er;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      er = N'(1) << (k % 4);
      n_checks++;
      if (bus.req_ready !== er) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", k, bus.req_ready, er);
      end
      if (k > 0) begin
        n_checks++;
        if (act_out() !== exp_out((k - 1) % 4)) begin
          n_fail++;
          $display("FAIL rr_out[%0d]: got %h expected %h", k, act_out(), exp_out((k - 1) % 4));
        end
      end
      @(negedge clock);
    end
    n_checks++;
    if (act_out() !== exp_out(3)) begin
      n_fail++;
      $display("FAIL rr_last: got %h expected %h", act_out(), exp_out(3));
    end
    bus.req_valid = 4'b0000;
    @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle_valid: got %b expected 0", bus.out_valid);
    end
  endtask

  // ptr = 0 on entry; single request from FU 2.
  task automatic test_single();
    bus.req_valid = 4'b0100;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b expected 0100", bus.req_ready);
    end
    @(negedge clock);
    n_checks++;
    if (act_out() !== exp_out(2)) begin
      n_fail++;
      $display("FAIL single_out: got %h expected %h", act_out(), exp_out(2));
    end
    bus.req_valid = 4'b0000;
  endtask

  // ptr = 3 on entry; sparse requests wrap to 0 then 1.
  task automatic test_wrap();
    bus.req_valid = 4'b0011;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_ready0: got %b expected 0001", bus.req_ready);
    end
    @(negedge clock);
    n_checks++;
    if (act_out() !== exp_out(0)) begin
      n_fail++;
      $display("FAIL wrap_out0: got %h expected %h", act_out(), exp_out(0));
    end
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_ready1: got %b expected 0010", bus.req_ready);
    end
    @(negedge clock);
    n_checks++;
    if (act_out() !== exp_out(1)) begin
      n_fail++;
      $display("FAIL wrap_out1: got %h expected %h", act_out(), exp_out(1));
    end
    bus.req_valid = 4'b0000;
  endtask

  // ptr = 2 on entry; load FU 1, then stall for three cycles.
  task automatic test_stall();
    bus.req_valid = 4'b0010;
    @(negedge clock);
    n_checks++;
    if (act_out() !== exp_out(1)) begin
      n_fail++;
      $display("FAIL stall_load: got %h expected %h", act_out(), exp_out(1));
    end
    bus.out_stall = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_ready[%0d]: got %b expected 0000", k, bus.req_ready);
      end
      @(negedge clock);
      n_checks++;
      if (act_out() !== exp_out(1)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", k, act_out(), exp_out(1));
      end
    end
    bus.out_stall = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b expected 0100", bus.req_ready);
    end
    @(negedge clock);
    n_checks++;
    if (act_out() !== exp_out(2)) begin
      n_fail++;
      $display("FAIL stall_release_out: got %h expected %h", act_out(), exp_out(2));
    end
  endtask

  // ptr = 3, out_valid = 1, all requesting on entry.
  task automatic test_flush();
    flush = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_ready: got %b expected 0000", bus.req_ready);
    end
    @(negedge clock);
    flush = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_valid: got %b expected 0", bus.out_valid);
    end
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL flush_ptr_ready: got %b expected 1000", bus.req_ready);
    end
    @(negedge clock);
    n_checks++;
    if (act_out() !== exp_out(3)) begin
      n_fail++;
      $display("FAIL flush_next_out: got %h expected %h", act_out(), exp_out(3));
    end
    bus.req_valid = 4'b0000;
    @(negedge clock);
  endtask

  // ptr = 0 on entry; reset hits while output is valid and stalled.
  task automatic test_async_reset();
    bus.req_valid = 4'b0001;
    @(negedge clock);
    n_checks++;
    if (act_out() !== exp_out(0)) begin
      n_fail++;
      $display("FAIL areset_pre: got %h expected %h", act_out(), exp_out(0));
    end
    bus.out_stall = 1'b1;
    bus.req_valid = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (act_out() !== '0) begin
      n_fail++;
      $display("FAIL areset_out: got %h expected 0", act_out());
    end
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_ready: got %b expected 0000", bus.req_ready);
    end
    @(negedge clock);
    reset         = 1'b0;
    bus.out_stall = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL areset_ptr: got %b expected 0001", bus.req_ready);
    end
    bus.req_valid = 4'b1000;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL areset_ready3: got %b expected 1000", bus.req_ready);
    end
    @(negedge clock);
    n_checks++;
    if (act_out() !== exp_out(3)) begin
      n_fail++;
      $display("FAIL areset_out3: got %h expected %h", act_out(), exp_out(3));
    end
    bus.req_valid = 4'b0000;
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.out_stall = 1'b0;
    bus.req_valid = '0;
    load_tables();
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_stall();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/complete_arbiter.md
Name: complete_arbiter

Overview:
Arbitrates up to NUM_REQ functional-unit completion requests onto the single completion broadcast consumed by the ROB (complete_en/complete_idx/result/rs2_value/take_branch) and by tag wakeup. It selects one request per cycle using round-robin priority. The selected request is registered into one output stage with a valid/stall handshake. It sits between the execute stage and the ROB/reservation-station broadcast.

Parameters:
NUM_REQ, 4, number of requesting functional units (2..8)
XLEN, 32, data width of result and rs2_value
ROB_IDX_W, $clog2(`ROB_SZ), width of the ROB index
TAG_W, $clog2(`PHYS_REG_SZ), width of the physical tag

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash (interrupt/mispredict); drops all in-flight completions
req_valid  in  NUM_REQ  per-FU completion request
req_ready  out  NUM_REQ  per-FU grant; a transfer occurs when req_valid[i] && req_ready[i]
req_rob_idx  in  NUM_REQ*ROB_IDX_W  ROB index per requester
req_tag  in  NUM_REQ*TAG_W  destination physical tag per requester
req_result  in  NUM_REQ*XLEN  result per requester
req_rs2_value  in  NUM_REQ*XLEN  store data per requester
req_take_branch  in  NUM_REQ  branch outcome per requester
out_stall  in  1  downstream cannot accept the output this cycle
out_valid  out  1  maps to complete_en
out_rob_idx  out  ROB_IDX_W  maps to complete_idx
out_tag  out  TAG_W  broadcast tag
out_result  out  XLEN  registered result
out_rs2_value  out  XLEN  registered rs2_value
out_take_branch  out  1  registered branch outcome
out_src  out  $clog2(NUM_REQ)  index of the requester that produced the current output

Behaviour:
- Reset (async, active-high): out_valid=0, out_rob_idx/out_tag/out_result/out_rs2_value/out_take_branch/out_src=0, RR pointer=0, req_ready=0 while reset is asserted.
- can_load = !out_valid || !out_stall. This is combinational and is the only path from out_stall to req_ready.
- Grant: when can_load, exactly one req_ready bit is set. It is the first i with req_valid[i], searching from ptr and wrapping modulo NUM_REQ. When !can_load, or no request is valid, req_ready is all zero. req_ready never asserts for an invalid requester.
- Latency: one cycle. A request granted in cycle N appears on out_* in cycle N+1 with out_valid=1.
- Output hold: while out_valid && out_stall, every out_* field stays stable.
- Output update when can_load:
  - a grant loads the output register and sets out_valid=1;
  - no grant clears out_valid to 0; data fields may hold stale values.
- Pointer: on a grant to g, ptr <= (g+1) mod NUM_REQ. Otherwise ptr holds. Wrap goes from NUM_REQ-1 to 0.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Flush (synchronous):
  - next cycle out_valid=0; ptr holds;
  - req_ready is forced to 0 in the flush cycle, so no transfer occurs;
  - flush has priority over load and over stall.
- Simultaneous load and consume: when out_valid && !out_stall and a new grant occurs, the output is replaced in the same edge. Back-to-back throughput is 1 per cycle.
- Width: all vectors are packed with requester i occupying slice [i*W +: W]. out_src is zero-extended from the grant index.

Decomposition:
- Shared package: TAG_W, ROB_IDX_W, and a COMPLETE_PACKET struct {rob_idx, tag, result, rs2_value, take_branch}. The IC_ROB_PACKET is populated from the COMPLETE_PACKET fields. NUM_REQ default is defined as `NUM_FU.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs: req[N], ptr, en;
  - outputs: grant one-hot, grant_idx, any_grant;
  - purely combinational, with a rotate–priority-encode–unrotate structure.
- complete_arbiter owns the pointer register, the output register and flush handling.

Test Plan:
- Single request: req_valid=0100, out_stall=0 -> req_ready=0100 same cycle; next cycle out_valid=1, out_src=2, out_rob_idx equals req_rob_idx[2]; ptr becomes 3.
- All requesters held valid for 8 cycles, out_stall=0 -> grant order 0,1,2,3,0,1,2,3; out_valid=1 every cycle after the first.
- Stall hold: output valid with out_src=1, out_stall=1 for 3 cycles while req_valid=1111 -> req_ready=0000 and out_* unchanged; on release, the next grant goes to 2.
- Flush mid-traffic: out_valid=1, flush=1 with req_valid=1111 -> req_ready=0000 that cycle; next cycle out_valid=0; ptr unchanged; the following grant uses the old ptr.
- Wrap and sparse: ptr=3, req_valid=0011 -> grant 0, then ptr=1 -> grant 1.
- Async reset while out_valid=1 and out_stall=1 -> out_valid=0 and req_ready=0 immediately, without waiting for a clock edge; after deassert, req_valid=1000 -> grant 3.
